// File: rtl/pixel_mem_slave.sv
// Pixel frame store: DEPTH x 24-bit single-port RAM behind a request/hready slave port.
// Define PIXEL_MEM_BOUNDS_CHECK_EN to add addr_err and drop/zero out-of-range accesses.
module pixel_mem_slave #(
    parameter int unsigned DEPTH       = 183184,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic [31:0] wr_count
`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
    ,
    output logic        addr_err
`endif
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t           r_state;
    logic [23:0]      r_mem [DEPTH];
    logic [IDX_W-1:0] r_idx;
    logic             r_write;
    logic [23:0]      r_data;
    logic [31:0]      r_last_addr;
    logic [3:0]       r_wait_cnt;
    logic [31:0]      r_hrdata;
    logic [31:0]      r_wr_count;
    logic             r_hready;

    logic             w_detect;
    logic             w_in_range;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_hwdata;

    // Reads fire only on an address change; writes fire whenever hwrite is high.
    assign w_detect        = hwrite || (haddr != r_last_addr);
    assign w_idx           = IDX_W'(haddr % DEPTH);
    assign w_unused_hwdata = ^hwdata[31:24];

`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
    logic r_oob;
    logic r_addr_err;
    assign w_in_range = ~r_oob;
    assign addr_err   = r_addr_err;
`else
    assign w_in_range = 1'b1;
`endif

    assign w_mem_we = n_rst && (r_state == StResp) && r_write && w_in_range;

    assign hrdata   = r_hrdata;
    assign hready   = r_hready;
    assign wr_count = r_wr_count;

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_data      <= '0;
            r_last_addr <= 32'hFFFF_FFFF;
            r_wait_cnt  <= '0;
            r_hrdata    <= '0;
            r_wr_count  <= '0;
            r_hready    <= 1'b0;
`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
            r_oob       <= 1'b0;
            r_addr_err  <= 1'b0;
`endif
        end else begin
            r_hready <= 1'b0;
`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
            r_addr_err <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (w_detect) begin
                        r_idx       <= w_idx;
                        r_write     <= hwrite;
                        r_data      <= hwdata[23:0];
                        r_last_addr <= haddr;
                        r_wait_cnt  <= '0;
`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
                        r_oob       <= (haddr >= DEPTH);
`endif
                        r_state     <= (WAIT_CYCLES > 1) ? StWait : StResp;
                    end
                end
                StWait: begin
                    if (r_wait_cnt == 4'(WAIT_CYCLES - 2)) begin
                        r_state <= StResp;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                StResp: begin
                    r_state  <= StIdle;
                    r_hready <= 1'b1;
`ifdef PIXEL_MEM_BOUNDS_CHECK_EN
                    r_addr_err <= r_oob;
`endif
                    if (r_write) begin
                        if (w_in_range) begin
                            r_wr_count <= r_wr_count + 32'd1;
                        end
                    end else begin
                        r_hrdata <= w_in_range ? {r_mem[r_idx], 8'h00} : 32'h0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/pixel_mem_slave.md
PIXEL_MEM_SLAVE -- requirements
Module: pixel_mem_slave

Interface
REQ-001 Parameter DEPTH, default 183184; number of 24-bit pixel words stored (428*428).
REQ-002 Parameter WAIT_CYCLES, default 1; cycles from request detection to the hready pulse; legal range is 1..15.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port n_rst  input  1  reset; synchronous, active-low.
REQ-005 Port haddr  input  32  pixel-word address driven by the master.
REQ-006 Port hwrite  input  1  1 = write request, 0 = read-mode address presentation.
REQ-007 Port hwdata  input  32  write data; pixel is {R,G,B} in bits [23:16],[15:8],[7:0]; bits [31:24] are ignored.
REQ-008 Port hrdata  output  32  read data, formatted {R,G,B,8'h00}.
REQ-009 Port hready  output  1  one-cycle transfer-complete pulse.
REQ-010 Port wr_count  output  32  count of completed writes since reset.
REQ-011 Port addr_err  output  1  one-cycle pulse for an out-of-range access; present only with the macro in REQ-033.

Function
REQ-012 The block shall hold a DEPTH x 24-bit pixel array, inferred as a single-port RAM.
REQ-013 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, a write request is detected on any cycle with hwrite=1.
REQ-015 In IDLE, a read request is detected on any cycle with hwrite=0 and haddr != last_addr.
REQ-016 On detection, the block shall latch haddr, hwrite and hwdata[23:0], and load last_addr with haddr.
REQ-017 Detection shall go to WAIT when WAIT_CYCLES>1 and straight to RESP when WAIT_CYCLES=1.
REQ-018 WAIT shall count WAIT_CYCLES-1 cycles, then go to RESP.
REQ-019 RESP shall last exactly one cycle with hready=1, then return to IDLE.
REQ-020 Latency shall be: request sampled at edge t, hready high in the cycle following edge t+WAIT_CYCLES; minimum throughput is one transfer per WAIT_CYCLES+1 cycles.
REQ-021 Read: hrdata shall be loaded with {mem[addr],8'h00} on entry to RESP and shall hold that value until the next read's RESP.
REQ-022 Write: mem[addr] shall be updated with the latched data on the RESP cycle; wr_count increments by 1 on that cycle; hrdata is unchanged.
REQ-023 haddr, hwrite and hwdata shall be ignored outside IDLE; a master change mid-transaction does not alter the latched request.
REQ-024 While hwrite is held at 1, back-to-back writes shall occur every WAIT_CYCLES+1 cycles, even at the same address.
REQ-025 A read of the address just written or just read shall not trigger, because last_addr matches; the master shall change the address to read again.
REQ-026 Addresses shall be compared in full 32 bits for read detection.
REQ-027 wr_count shall wrap modulo 2^32 without saturation.
REQ-028 With the macro in REQ-033 undefined, the memory index shall be addr modulo DEPTH.

Reset
REQ-029 While n_rst=0 at a clock edge, the next state shall be: FSM=IDLE, hready=0, hrdata=0, wr_count=0, addr_err=0, last_addr=32'hFFFF_FFFF, wait counter=0.
REQ-030 Memory contents shall not be reset.
REQ-031 Reset asserted in WAIT or RESP shall abandon the transaction: no memory write, no wr_count increment, no hready.
REQ-032 The first IDLE cycle after release shall be able to detect a request, including a read of address 0.

Configuration
REQ-033 Macro PIXEL_MEM_BOUNDS_CHECK_EN, when defined:
  - addr >= DEPTH yields addr_err=1 in the RESP cycle alongside hready=1;
  - an out-of-range read returns hrdata=32'h0;
  - an out-of-range write is dropped and wr_count is not incremented.
REQ-034 When PIXEL_MEM_BOUNDS_CHECK_EN is undefined, the addr_err port and its logic shall be absent, and out-of-range addresses shall alias modulo DEPTH per REQ-028.

Verification
REQ-035 Reset, then read: hwrite=0, haddr=0, mem[0]=24'h112233 preloaded -> hready pulse 1 cycle after detection (WAIT_CYCLES=1); hrdata=32'h11223300.
REQ-036 Write then read back: write haddr=5, hwdata=32'hFFAABBCC -> hready pulse and wr_count=1; then read haddr=6, then read haddr=5 -> hrdata=32'hAABBCC00.
REQ-037 Repeat read: haddr held at 7 with hwrite=0 for 10 cycles -> exactly one hready pulse.
REQ-038 WAIT_CYCLES=4: read at addr 3 -> hready pulses 4 cycles after the detection edge; a haddr change during WAIT is ignored and hrdata reflects addr 3.
REQ-039 Reset mid-write: n_rst=0 during WAIT with a write to addr 9 -> mem[9] unchanged, wr_count=0, no hready pulse.
REQ-040 Bounds check, macro defined: write to addr DEPTH -> addr_err and hready pulse together, wr_count unchanged. Macro undefined: the same write lands in mem[0].
